// File: rtl/decodificador_pkg.sv
// rtl/decodificador_pkg.sv - shared glyph table and segment constants
// Purpose: active-low seven-segment glyphs for hex digits 0..F, plus the
//          dark and lit patterns, all in [0:6] = a..g order.
// Ports:   none (package)
package decodificador_pkg;

    typedef logic [0:6] seg_t;

    // Active-low reference patterns; the top inverts them for active-high panels.
    localparam seg_t SEG_DARK = 7'b1111111;
    localparam seg_t SEG_LIT  = 7'b0000000;

    // Lowercase b and d keep 4'hB/4'hD distinct from 8 and 0.
    localparam seg_t GLYPH_TABLE [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

endpackage

// File: rtl/decodificador_seg7_lut.sv
// rtl/decodificador_seg7_lut.sv - combinational hex digit to active-low glyph map
// Purpose: pure lookup into the shared glyph table.
// Ports:   digit - 4-bit hex digit in
//          seg   - 7-bit active-low glyph out, [0:6] = a..g
module seg7_lut
    import decodificador_pkg::*;
(
    input  logic [3:0] digit,
    output logic [0:6] seg
);

    assign seg = GLYPH_TABLE[digit];

endmodule

// File: rtl/decodificador.sv
// rtl/decodificador.sv - registered seven-segment hex decoder with blank and lamp test
// Purpose: decodes SW to a hex glyph with one clock of latency; priority
//          RESET > BLANK > LT > decode; output polarity set by SEG_ACTIVE_LOW.
// Ports:   CLOCK_50 - system clock, rising edge
//          RESET    - synchronous active-high reset, loads the dark pattern
//          SW       - hex digit to display
//          BLANK    - forces all segments dark
//          LT       - lamp test, forces all segments lit
//          HEX3     - registered segment drive, [0:6] = a..g
module decodificador
    import decodificador_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [3:0] SW,
    input  logic       BLANK,
    input  logic       LT,
    output logic [0:6] HEX3
);

    // All table entries are active-low; XOR with this mask gives panel polarity.
    localparam seg_t POL_MASK = SEG_ACTIVE_LOW ? 7'b0000000 : 7'b1111111;
    localparam seg_t DARK_P   = SEG_DARK ^ POL_MASK;
    localparam seg_t LIT_P    = SEG_LIT  ^ POL_MASK;

    seg_t glyph;

    seg7_lut u_lut (
        .digit (SW),
        .seg   (glyph)
    );

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            HEX3 <= DARK_P;
        end else if (BLANK) begin
            HEX3 <= DARK_P;
        end else if (LT) begin
            HEX3 <= LIT_P;
        end else begin
            HEX3 <= glyph ^ POL_MASK;
        end
    end

endmodule

// File: tb/tb_decodificador.sv
// tb/tb_decodificador.sv - directed self-checking bench for decodificador
module tb_decodificador;

    logic       CLOCK_50 = 1'b0;
    logic       RESET    = 1'b1;
    logic [3:0] SW       = 4'h8;
    logic       BLANK    = 1'b0;
    logic       LT       = 1'b0;
    logic [0:6] hex_al;
    logic [0:6] hex_ah;

    int checks = 0;
    int errors = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    decodificador #(.SEG_ACTIVE_LOW(1'b1)) dut_al (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .SW       (SW),
        .BLANK    (BLANK),
        .LT       (LT),
        .HEX3     (hex_al)
    );

    decodificador #(.SEG_ACTIVE_LOW(1'b0)) dut_ah (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .SW       (SW),
        .BLANK    (BLANK),
        .LT       (LT),
        .HEX3     (hex_ah)
    );

    // Hand-written active-low glyphs, index = SW value.
    logic [0:6] exp_tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    task automatic check(input string tag, input logic [0:6] got, input logic [0:6] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Checks both polarities from one active-low expectation.
    task automatic check_both(input string tag, input logic [0:6] exp_low);
        check({tag, "_al"}, hex_al, exp_low);
        check({tag, "_ah"}, hex_ah, ~exp_low);
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        // Reset held two edges with SW=8.
        step();
        check_both("rst_edge1", 7'b1111111);
        step();
        check_both("rst_edge2", 7'b1111111);
        RESET = 1'b0;
        step();
        check_both("post_rst_8", 7'b0000000);

        // Full sweep, one digit per clock.
        for (int i = 0; i < 16; i++) begin
            SW = 4'(i);
            step();
            check_both($sformatf("sweep_%0h", i), exp_tbl[i]);
        end

        // Blank / lamp-test priority.
        SW = 4'h2; BLANK = 1'b1; LT = 1'b1;
        step();
        check_both("blank_lt", 7'b1111111);
        BLANK = 1'b0;
        step();
        check_both("lt_only", 7'b0000000);
        LT = 1'b0;
        step();
        check_both("decode_2", 7'b0010010);
        BLANK = 1'b1;
        step();
        check_both("blank_only", 7'b1111111);
        BLANK = 1'b0;

        // Inputs wiggled between edges must not reach the output.
        SW = 4'h5;
        step();
        check_both("hold_5", 7'b0100100);
        #4;
        SW = 4'h3; LT = 1'b1; BLANK = 1'b1;
        #2;
        RESET = 1'b1;
        #2;
        check_both("between_edges", 7'b0100100);
        RESET = 1'b0; LT = 1'b0; BLANK = 1'b0;
        step();
        check_both("next_edge_3", 7'b0000110);

        // Reset mid-sweep at SW=A overrides lamp test.
        for (int i = 8; i < 10; i++) begin
            SW = 4'(i);
            step();
            check_both($sformatf("resweep_%0h", i), exp_tbl[i]);
        end
        SW = 4'hA; RESET = 1'b1; LT = 1'b1;
        step();
        check_both("rst_over_lt", 7'b1111111);
        RESET = 1'b0; LT = 1'b0;
        step();
        check_both("after_rst_A", 7'b0001000);
        SW = 4'h1;
        step();
        check_both("decode_1", 7'b1001111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
